pipe_stage_reg: RTL

- Generic parametrised pipeline-stage register that replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 5-stage core.
- Carries a control bundle and a data payload between adjacent stages.
- Supports a valid/ready handshake, stall (hold) and flush (bubble insertion), plus an optional skid entry so that ready_o is registered.
- Provides a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_slot.sv | 43 ++++
 rtl/pipe_stage_reg.sv | 110 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage registers: control-bundle layout
// and the ID/EX payload format.
package pipe_pkg;

  localparam int unsigned WB_W   = 2;
  localparam int unsigned MEM_W  = 3;
  localparam int unsigned EX_W   = 4;
  localparam int unsigned CTRL_W = WB_W + MEM_W + EX_W;

  // Field offsets inside the control bundle, ex in the low bits.
  localparam int unsigned EX_LSB  = 0;
  localparam int unsigned MEM_LSB = EX_LSB + EX_W;
  localparam int unsigned WB_LSB  = MEM_LSB + MEM_W;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  typedef struct packed {
    logic [WB_W-1:0]  wb;
    logic [MEM_W-1:0] mem;
    logic [EX_W-1:0]  ex;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rsdata;
    logic [31:0] rtdata;
    logic [31:0] imm;
    logic [4:0]  rsaddr;
    logic [4:0]  rtaddr;
    logic [4:0]  rdaddr;
  } id_ex_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit, control bundle and payload with
// load / clear / hold. Clear wins over load; ctrl reads as zero when invalid.
module pipe_slot #(
  parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] next_ctrl,
  input  logic [DATA_W-1:0] next_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);
  import pipe_pkg::*;

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Clear leaves the payload untouched; only valid and ctrl form the bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      ctrl_q  <= next_ctrl;
      data_q  <= next_data;
    end
  end

  assign valid = valid_q;
  assign ctrl  = valid_q ? ctrl_q : '0;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake, flush,
// optional skid entry for a registered ready_o, and a saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned CTRL_W  = pipe_pkg::CTRL_W,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  import pipe_pkg::*;

  localparam bit UseSkid = (SKID_EN != 0);

  logic              out_valid, out_load, out_clear, out_free;
  logic              skid_raw_valid, skid_valid, skid_load, skid_clear;
  logic [CTRL_W-1:0] out_ctrl, skid_ctrl, out_next_ctrl;
  logic [DATA_W-1:0] out_data, skid_data, out_next_data;
  logic              accept, emit;
  logic [CNT_W-1:0]  stall_cnt;

  // With the skid disabled its slot is never loaded and its valid is masked off.
  assign skid_valid = UseSkid & skid_raw_valid;
  assign out_free   = !out_valid | ready_i;
  assign ready_o    = UseSkid ? !skid_valid : out_free;
  assign accept     = valid_i & ready_o;
  assign emit       = out_valid & ready_i;

  always_comb begin
    out_load      = 1'b0;
    out_clear     = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    out_next_ctrl = ctrl_i;
    out_next_data = data_i;
    if (flush_i) begin
      out_clear  = 1'b1;
      skid_clear = 1'b1;
    end else if (out_free) begin
      if (skid_valid) begin
        // Oldest waiting entry moves up; ready_o is low so nothing is accepted.
        out_load      = 1'b1;
        out_next_ctrl = skid_ctrl;
        out_next_data = skid_data;
        skid_clear    = 1'b1;
      end else if (accept) begin
        out_load = 1'b1;
      end else if (emit) begin
        out_clear = 1'b1;
      end
    end else if (accept) begin
      skid_load = 1'b1;
    end
  end

  pipe_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_out (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (out_load),
    .clear    (out_clear),
    .next_ctrl(out_next_ctrl),
    .next_data(out_next_data),
    .valid    (out_valid),
    .ctrl     (out_ctrl),
    .data     (out_data)
  );

  pipe_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (skid_load),
    .clear    (skid_clear),
    .next_ctrl(ctrl_i),
    .next_data(data_i),
    .valid    (skid_raw_valid),
    .ctrl     (skid_ctrl),
    .data     (skid_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (out_valid && !ready_i && !flush_i && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign valid_o     = out_valid;
  assign ctrl_o      = out_ctrl;
  assign data_o      = out_data;
  assign stall_cnt_o = stall_cnt;

endmodule
